instruction_fetch_queue: RTL and testbench

- Pipeline-side fetch stage sitting directly downstream of the instruction prefetch unit.
- Generates the sequential fetch PC and presents it to the prefetcher.
- Captures returned instructions into a small FIFO that feeds decode.
- Handles branch redirects by flushing the queue and restarting the PC.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instruction_fetch_queue.sv | 109 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and queue-entry layout for the instruction fetch stage.
// A queue entry is the concatenation {pc, instr}, with pc in the upper bits.
package fetch_pkg;
  localparam int ADDR_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int WORD_INCR  = 4;
  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int ENTRY_W    = ADDR_W + INSTR_W;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Generic circular-buffer FIFO, DEPTH x WIDTH.
// Ports: clock, reset (sync, active-high), push/wr_data, pop/rd_data,
//        flush (empties the buffer next cycle), count, full, empty.
// Pointers carry one extra bit beyond the index width; only the low bits
// address the storage. A push is honoured when full only if a pop happens
// in the same cycle, and a pop is ignored when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end
endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage between the instruction prefetcher and decode.
// Generates the sequential fetch PC, captures returned words into a small
// queue feeding decode, and flushes/restarts on a branch redirect.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   fetch_addr/fetch_req    - current PC and request-live flag to prefetcher
//   fetch_wait/fetch_instr  - prefetcher stall and returned word
//   redirect_valid/_addr    - redirect strobe and target from execute
//   dec_valid/ready/instr/pc- head of queue toward decode
// Optional: define FETCH_PERF_CNT_EN to add saturating stall_cycles (32b)
// and flush_count (16b) performance counter outputs.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = fetch_pkg::ADDR_W,
  parameter int                INSTR_W      = fetch_pkg::INSTR_W,
  parameter int                DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_req,
  input  logic               fetch_wait,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);
  localparam int E_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]      pc;
  logic [E_W-1:0]         head;
  logic [ADDR_W-1:0]      head_pc;
  logic [INSTR_W-1:0]     head_instr;
  logic [ADDR_W-1:0]      last_pc;
  logic [INSTR_W-1:0]     last_instr;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   accept;
  logic                   room;

  // Room for a push this cycle: not full, or the head leaves as we push.
  assign pop       = dec_valid & dec_ready;
  assign room      = ~full | pop;
  assign fetch_req = ~reset & room;
  // A redirect cancels both the push and the pop of its cycle.
  assign accept    = fetch_req & ~fetch_wait & ~redirect_valid & room;

  assign fetch_addr = pc;
  assign dec_valid  = ~empty;
  assign {head_pc, head_instr} = head;
  // While empty, decode keeps seeing the last head it was shown.
  assign dec_pc    = empty ? last_pc    : head_pc;
  assign dec_instr = empty ? last_instr : head_instr;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(E_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (accept),
    .wr_data ({pc, fetch_instr}),
    .pop     (pop & ~redirect_valid),
    .flush   (redirect_valid),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock) begin
    if (reset)               pc <= RESET_VECTOR;
    else if (redirect_valid) pc <= {redirect_addr[ADDR_W-1:2], 2'b00};
    else if (accept)         pc <= pc + ADDR_W'(WORD_INCR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_pc    <= '0;
      last_instr <= '0;
    end else if (!empty) begin
      last_pc    <= head_pc;
      last_instr <= head_instr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (fetch_req && fetch_wait && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (redirect_valid && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios plus
// a randomized run compared against a queue-based reference model.
module tb_instruction_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        fetch_wait;
  logic [31:0] fetch_instr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_addr     (fetch_addr),
    .fetch_req      (fetch_req),
    .fetch_wait     (fetch_wait),
    .fetch_instr    (fetch_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: a queue of {pc, instr} words, the fetch PC, and the
  // last head value decode was shown.
  logic [63:0] m_q[$];
  logic [31:0] m_pc   = RV;
  logic [63:0] m_last = '0;

  function automatic logic exp_req();
    return !reset && (m_q.size() < DEPTH || (m_q.size() > 0 && dec_ready));
  endfunction
  function automatic logic [63:0] exp_head();
    return (m_q.size() > 0) ? m_q[0] : m_last;
  endfunction

  task automatic drive(input logic r, input logic w, input logic rv,
                       input logic [31:0] ra, input logic rdy,
                       input logic [31:0] ins);
    reset = r; fetch_wait = w; redirect_valid = rv;
    redirect_addr = ra; dec_ready = rdy; fetch_instr = ins;
    #1;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic step();
    logic pop, acc;
    pop = (m_q.size() > 0) && dec_ready;
    acc = !reset && !fetch_wait && !redirect_valid && (m_q.size() < DEPTH || pop);
    if (reset) begin
      m_q.delete(); m_pc = RV; m_last = '0;
    end else begin
      if (m_q.size() > 0) m_last = m_q[0];
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_addr & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (acc) begin
          m_q.push_back({m_pc, fetch_instr});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", fetch_req); end
    step();
    drive(0, 1, 0, 0, 0, 0);
    checks++; if (fetch_addr !== RV) begin errors++; $display("FAIL reset_pc got %h want %h", fetch_addr, RV); end
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_req_after got %b want 1", fetch_req); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dec_valid); end
    checks++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
      errors++; $display("FAIL reset_dec got %h/%h want 0/0", dec_pc, dec_instr); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, m_pc);
      checks++; if (fetch_addr !== 32'(4*i) || fetch_req !== 1'b1) begin
        errors++; $display("FAIL fill_addr got %h/%b want %h/1", fetch_addr, fetch_req, 32'(4*i)); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, m_pc);
      checks++; if (fetch_req !== 1'b0 || fetch_addr !== 32'h10) begin
        errors++; $display("FAIL fill_full got %b/%h want 0/00000010", fetch_req, fetch_addr); end
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
        errors++; $display("FAIL fill_head got %b/%h/%h want 1/0/0", dec_valid, dec_pc, dec_instr); end
      step();
    end
  endtask

  // Continues from a full queue: pop and push every cycle.
  task automatic test_full_pop();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1, m_pc);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4*i) || dec_instr !== 32'(4*i) || fetch_req !== 1'b1) begin
        errors++; $display("FAIL fullpop_head got %b/%h/%h/%b want 1/%h/%h/1",
                           dec_valid, dec_pc, dec_instr, fetch_req, 32'(4*i), 32'(4*i)); end
      step();
    end
    drive(0, 0, 0, 0, 0, m_pc);
    checks++; if (fetch_req !== 1'b0 || dec_pc !== 32'h18) begin
      errors++; $display("FAIL fullpop_still_full got %b/%h want 0/00000018", fetch_req, dec_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, m_pc ^ 32'hDEAD_BEEF);
      if (i > 0) begin
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4*(i-1)) || dec_instr !== (32'(4*(i-1)) ^ 32'hDEAD_BEEF)) begin
          errors++; $display("FAIL stream got %b/%h/%h want 1/%h", dec_valid, dec_pc, dec_instr, 32'(4*(i-1))); end
      end
      step();
    end
  endtask

  // Continues from streaming: pc = 0x20 with 0x1C at the head.
  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 1, 32'h0);
      checks++; if (fetch_addr !== 32'h20) begin
        errors++; $display("FAIL stall_addr got %h want 00000020", fetch_addr); end
      checks++; if (dec_valid !== (i == 0) || dec_pc !== 32'h1C) begin
        errors++; $display("FAIL stall_drain got %b/%h want %b/0000001c", dec_valid, dec_pc, (i == 0)); end
      step();
    end
    drive(0, 1, 0, 0, 0, 32'h0);
    checks++; if (fetch_addr !== 32'h20 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL stall_end got %h/%b want 00000020/0", fetch_addr, dec_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd3) begin
      errors++; $display("FAIL stall_count got %0d want 3", stall_cycles); end
`endif
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, m_pc); step(); end
    drive(0, 0, 1, 32'h1003, 1, 32'hBAD0_BAD0);
    step();
    drive(0, 0, 0, 0, 0, m_pc);
    checks++; if (dec_valid !== 1'b0 || fetch_addr !== 32'h1000 || fetch_req !== 1'b1) begin
      errors++; $display("FAIL redirect_flush got %b/%h/%b want 0/00001000/1", dec_valid, fetch_addr, fetch_req); end
    step();
    drive(0, 1, 0, 0, 0, 0);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h1000 || dec_instr !== 32'h1000) begin
      errors++; $display("FAIL redirect_refill got %b/%h/%h want 1/00001000/00001000", dec_valid, dec_pc, dec_instr); end
  endtask

  task automatic test_wrap_reset();
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0, 0, m_pc); step(); end
    drive(0, 1, 0, 0, 1, 0);
    checks++; if (fetch_addr !== 32'h4 || dec_pc !== 32'hFFFF_FFFC || dec_instr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first got %h/%h want 00000004/fffffffc", fetch_addr, dec_pc); end
    step();
    drive(0, 0, 0, 0, 1, m_pc);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
      errors++; $display("FAIL wrap_second got %b/%h want 1/00000000", dec_valid, dec_pc); end
    step();
    drive(1, 0, 0, 0, 1, 32'h5555_5555);
    step();
    drive(0, 1, 0, 0, 1, 0);
    checks++; if (fetch_addr !== RV || dec_valid !== 1'b0 || fetch_req !== 1'b1 || dec_pc !== 32'h0) begin
      errors++; $display("FAIL midreset got %h/%b/%b/%h want %h/0/1/0", fetch_addr, dec_valid, fetch_req, dec_pc, RV); end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [63:0] h;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(3))
        0:       ra = 32'hFFFF_FFF0 | $urandom_range(15);
        default: ra = $urandom;
      endcase
      drive(($urandom_range(299) == 0), ($urandom_range(3) == 0), ($urandom_range(15) == 0),
            ra, $urandom_range(1), $urandom);
      h = exp_head();
      checks++;
      if (fetch_addr !== m_pc || fetch_req !== exp_req() || dec_valid !== (m_q.size() > 0) ||
          dec_pc !== h[63:32] || dec_instr !== h[31:0]) begin
        errors++;
        $display("FAIL random cyc %0d got addr %h req %b v %b pc %h in %h want %h %b %b %h %h",
                 n, fetch_addr, fetch_req, dec_valid, dec_pc, dec_instr,
                 m_pc, exp_req(), (m_q.size() > 0), h[63:32], h[31:0]);
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    test_reset();
    test_fill();
    test_full_pop();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
